// File: rtl/apb_master_bridge_if.sv
// Bundle of request/response and APB bus signals between the bridge and its environment.
// The master modport is the bridge's view; the slave modport is the requester/APB-slave side.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              PENABLE;
  logic              PSELECT1;
  logic              PSELECT2;
  logic              PREADY1;
  logic              PREADY2;
  logic [DATA_W-1:0] PRDATA1;
  logic [DATA_W-1:0] PRDATA2;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PREADY1, PREADY2, PRDATA1, PRDATA2,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PWRITE, PWDATA, PENABLE, PSELECT1, PSELECT2
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PREADY1, PREADY2, PRDATA1, PRDATA2,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PWRITE, PWDATA, PENABLE, PSELECT1, PSELECT2
  );

endinterface

// File: rtl/apb_master_bridge.sv
// APB3-style master bridging a valid/ready request port to two APB slaves, all outputs registered.
// Optional ACCESS-phase abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int SEL_BIT = 6
`ifdef APB_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state_q;
  logic              reqReady_q;
  logic              rspValid_q;
  logic [DATA_W-1:0] rspRdata_q;
  logic              rspErr_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              penable_q;
  logic              pselect1_q;
  logic              pselect2_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] accessCnt_q;
`endif

  // Ready/data come from whichever slave this transfer selected; the selects are stable in ACCESS.
  logic              selReady;
  logic [DATA_W-1:0] selRdata;

  always_comb begin
    selReady = pselect2_q ? bus.PREADY2 : bus.PREADY1;
    selRdata = pselect2_q ? bus.PRDATA2 : bus.PRDATA1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      reqReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      penable_q  <= 1'b0;
      pselect1_q <= 1'b0;
      pselect2_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      accessCnt_q <= '0;
`endif
    end else begin
      rspValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            paddr_q    <= bus.req_addr;
            pwrite_q   <= bus.req_write;
            pwdata_q   <= bus.req_wdata;
            pselect1_q <= ~bus.req_addr[SEL_BIT];
            pselect2_q <= bus.req_addr[SEL_BIT];
            reqReady_q <= 1'b0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          accessCnt_q <= '0;
`endif
        end
        ACCESS: begin
          if (selReady) begin
            rspValid_q <= 1'b1;
            rspRdata_q <= pwrite_q ? '0 : selRdata;
            rspErr_q   <= 1'b0;
            penable_q  <= 1'b0;
            pselect1_q <= 1'b0;
            pselect2_q <= 1'b0;
            reqReady_q <= 1'b1;
            state_q    <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          // Ready on the last counted cycle still wins over the abort above.
          else if (accessCnt_q == LAST_CNT) begin
            rspValid_q <= 1'b1;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b1;
            penable_q  <= 1'b0;
            pselect1_q <= 1'b0;
            pselect2_q <= 1'b0;
            reqReady_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            accessCnt_q <= accessCnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = reqReady_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_rdata = rspRdata_q;
  assign bus.rsp_err   = rspErr_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PSELECT1  = pselect1_q;
  assign bus.PSELECT2  = pselect2_q;

endmodule
